amp_limiter_ramp: RTL and testbench
===================================

# amp_limiter_ramp

Multi-channel, pipelined successor to the combinational gain limiter. Each incoming sample is multiplied by a fixed-point gain held per channel. The product is rounded, then saturated to the sample width. When software sets a new gain, the gain moves to it in bounded steps instead of jumping. The block sits in the streaming audio path between the sample source and the output formatter, and uses valid/ready handshakes on both sides.

## Interface
- DATA_W, 32, sample width, signed
- GAIN_W, 32, gain width, signed Q(GAIN_W-FRAC_W).FRAC_W
- FRAC_W, 16, gain fractional bits (0 gives plain integer gain)
- CHANNELS, 2, number of channels with their own gain
- RAMP_STEP, 256, largest gain change per applied sample, in gain LSBs; 0 means the new gain applies immediately
- GAIN_RESET, 1<<FRAC_W, reset value of every channel's target and current gain (unity)
- CH_W, max(1,$clog2(CHANNELS)), derived channel-index width
- clk  in  1  clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- gain_load  in  1  pulse: write gain_target into target[gain_ch]
- gain_ch  in  CH_W  channel selected by gain_load
- gain_target  in  GAIN_W  new target gain
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept an input sample
- in_data  in  DATA_W  signed input sample
- in_ch  in  CH_W  channel of the input sample
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream can accept
- out_data  out  DATA_W  limited sample
- out_ch  out  CH_W  channel, passed through from input
- out_gain  out  GAIN_W  gain that was applied to this sample
- out_clip  out  1  this sample was saturated
- clip_clr  in  1  synchronous clear of clip_count
- clip_count  out  16  count of clipped output samples; saturates at 0xFFFF

## Operation
- Pipeline has two registered stages: S1 holds the product, S2 holds the output registers.
- Pipeline enable: en = !out_valid || out_ready. in_ready = en. Both stages advance only when en = 1.
- An input sample is accepted when in_valid && in_ready.
- S1 captures:
  - the full signed product in_data * cur[in_ch], width DATA_W+GAIN_W
  - the channel and the gain used
- S2 computes r = (p + (FRAC_W>0 ? 1<<(FRAC_W-1) : 0)) >>> FRAC_W. This is round-half-up, arithmetic shift.
- S2 saturation:
  - r > 2^(DATA_W-1)-1 → out_data = 0x7FF..F, out_clip = 1
  - r < -2^(DATA_W-1) → out_data = 0x800..0, out_clip = 1
  - otherwise out_data = r[DATA_W-1:0], out_clip = 0
  - r exactly equal to a bound is not a clip.
- Samples with in_ch ≥ CHANNELS: out_data = 0, out_clip = 0, out_gain = 0. No ramp update.
- Gain ramp, per channel c, on each accepted sample with in_ch == c, after the current gain has been sampled:
  - cur[c] moves toward target[c] by min(RAMP_STEP, |target−cur|).
  - The new value applies from the next sample of channel c.
- RAMP_STEP = 0: cur[gain_ch] = gain_target on the cycle after gain_load. No ramping.
- gain_load in the same cycle as an accepted sample of the same channel:
  - that sample's ramp step uses the old target
  - the new target is stored at the same edge
- clip_count increments when an output beat is taken (out_valid && out_ready && out_clip).
  - It stops at 0xFFFF.
  - clip_clr has priority over a simultaneous increment; the result is 0.

## Timing
- Latency is 2 cycles from input acceptance to out_valid, with no backpressure.
- Throughput is 1 sample per cycle.
- While out_valid && !out_ready:
  - all output registers hold steady
  - in_ready = 0
  - the S1 contents are preserved
- in_ready is combinational from out_valid and out_ready. No other input-to-output combinational path exists.
- Reset values (asynchronous, on rst_n low):
  - out_valid = 0, S1 valid = 0
  - out_data = 0, out_ch = 0, out_gain = 0, out_clip = 0
  - clip_count = 0
  - target[c] = cur[c] = GAIN_RESET for every channel
  - in_ready = 1
- Reset in the middle of operation drops any samples still in flight. No output beat is produced for them.

## Test plan
- Test configuration: DATA_W = 16, GAIN_W = 16, FRAC_W = 8, CHANNELS = 2, RAMP_STEP = 64.
- Unity gain: ch0 samples 1000, −1000 → out 1000, −1000; out_gain = 256; out_clip = 0; out_valid two cycles after acceptance.
- Saturation, after ramping ch1 to gain 512:
  - 20000 → 32767, clip
  - −20000 → −32768, clip
  - 16383 → 32766, no clip
  - clip_count = 2
- Rounding with gain 128 (0.5): 3 → 2, −3 → −1, 2 → 1.
- Ramp: gain_load target 512 on ch0, then ch0 samples of 100 interleaved with ch1 samples:
  - ch0 out_gain sequence 256, 320, 384, 448, 512, 512
  - ch1 stays at 256
  - a load in the same cycle as a ch0 sample obeys the old-target rule
- Backpressure: stream 10 samples while out_ready toggles randomly. Required: no loss, no duplication, order preserved, outputs stable while stalled.
- Counter and reset:
  - force 0x10000 clips → clip_count holds 0xFFFF
  - clip_clr together with a clip beat → 0
  - assert rst_n mid-stream → outputs go to their reset values and gains return to 256

Source files
------------

// File: rtl/amp_limiter_ramp.sv
// Multi-channel gain limiter: per-channel ramped fixed-point gain feeding a
// two-stage multiply / round / saturate pipeline with valid/ready on both sides.
module amp_limiter_ramp #(
    parameter int DATA_W    = 32,
    parameter int GAIN_W    = 32,
    parameter int FRAC_W    = 16,
    parameter int CHANNELS  = 2,
    parameter int RAMP_STEP = 256,
    parameter logic signed [GAIN_W-1:0] GAIN_RESET = GAIN_W'(1) << FRAC_W,
    parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     gain_load,
    input  logic [CH_W-1:0]          gain_ch,
    input  logic signed [GAIN_W-1:0] gain_target,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]          in_ch,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic signed [GAIN_W-1:0] out_gain,
    output logic                     out_clip,
    input  logic                     clip_clr,
    output logic [15:0]              clip_count
);

    localparam int P_W = DATA_W + GAIN_W;
    localparam int R_W = P_W + 1;
    localparam int G_X = GAIN_W + 1;

    localparam logic signed [R_W-1:0] ROUND_K = (R_W'(1) << FRAC_W) >> 1;
    localparam logic signed [R_W-1:0] SAT_MAX = (R_W'(1) << (DATA_W - 1)) - R_W'(1);
    localparam logic signed [R_W-1:0] SAT_MIN = -(R_W'(1) << (DATA_W - 1));
    localparam logic signed [G_X-1:0] STEP_K  = G_X'(RAMP_STEP);

    localparam logic [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Handshake: a beat transfers on a rising edge where valid && ready. Valid
    // never depends on ready. The whole pipe advances together on
    // en = !out_valid || out_ready, and in_ready is exactly en.
    logic en;
    logic accept;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;

    logic signed [GAIN_W-1:0] target [CHANNELS];
    logic signed [GAIN_W-1:0] cur    [CHANNELS];

    // Channels outside the configured range see a gain of zero.
    logic signed [GAIN_W-1:0] sel_gain;

    always_comb begin
        sel_gain = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (in_ch == CH_W'(c)) begin
                sel_gain = cur[c];
            end
        end
    end

    function automatic logic signed [GAIN_W-1:0] ramp_next(
        input logic signed [GAIN_W-1:0] cur_g,
        input logic signed [GAIN_W-1:0] tgt_g
    );
        logic signed [G_X-1:0] cur_x;
        logic signed [G_X-1:0] tgt_x;
        logic signed [G_X-1:0] diff;
        cur_x = cur_g;
        tgt_x = tgt_g;
        diff  = tgt_x - cur_x;
        if (diff > STEP_K) begin
            return GAIN_W'(cur_x + STEP_K);
        end else if (diff < -STEP_K) begin
            return GAIN_W'(cur_x - STEP_K);
        end else begin
            return tgt_g;
        end
    endfunction

    // The step uses the target held before this edge; a simultaneous load
    // only becomes visible to the following sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                target[c] <= GAIN_RESET;
                cur[c]    <= GAIN_RESET;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (RAMP_STEP == 0) begin
                    if (gain_load && gain_ch == CH_W'(c)) begin
                        cur[c] <= gain_target;
                    end
                end else if (accept && in_ch == CH_W'(c)) begin
                    cur[c] <= ramp_next(cur[c], target[c]);
                end
                if (gain_load && gain_ch == CH_W'(c)) begin
                    target[c] <= gain_target;
                end
            end
        end
    end

    logic signed [P_W-1:0] in_x;
    logic signed [P_W-1:0] gain_x;
    logic signed [P_W-1:0] prod;

    always_comb begin
        in_x   = in_data;
        gain_x = sel_gain;
        prod   = in_x * gain_x;
    end

    logic                     s1_valid;
    logic signed [P_W-1:0]    s1_prod;
    logic [CH_W-1:0]          s1_ch;
    logic signed [GAIN_W-1:0] s1_gain;

    logic signed [R_W-1:0] prod_r;
    logic signed [R_W-1:0] biased;
    logic signed [R_W-1:0] rounded;
    logic [DATA_W-1:0]     sat_data;
    logic                  sat_clip;

    // Round half up, then floor via arithmetic shift; a result equal to a
    // bound is representable and therefore not a clip.
    always_comb begin
        prod_r  = s1_prod;
        biased  = prod_r + ROUND_K;
        rounded = biased >>> FRAC_W;
        if (rounded > SAT_MAX) begin
            sat_data = OUT_MAX;
            sat_clip = 1'b1;
        end else if (rounded < SAT_MIN) begin
            sat_data = OUT_MIN;
            sat_clip = 1'b1;
        end else begin
            sat_data = rounded[DATA_W-1:0];
            sat_clip = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_prod   <= '0;
            s1_ch     <= '0;
            s1_gain   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_gain  <= '0;
            out_clip  <= 1'b0;
        end else if (en) begin
            s1_valid <= accept;
            if (accept) begin
                s1_prod <= prod;
                s1_ch   <= in_ch;
                s1_gain <= sel_gain;
            end
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= sat_data;
                out_ch   <= s1_ch;
                out_gain <= s1_gain;
                out_clip <= sat_clip;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_count <= '0;
        end else if (clip_clr) begin
            clip_count <= '0;
        end else if (out_valid && out_ready && out_clip && clip_count != 16'hFFFF) begin
            clip_count <= clip_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_amp_limiter_ramp.sv
// Bench for amp_limiter_ramp: directed steps plus random traffic, scored
// against an arithmetic model of gain, rounding, saturation and ramping.
module tb_amp_limiter_ramp;

    localparam int DW   = 16;
    localparam int GW   = 16;
    localparam int FW   = 8;
    localparam int NCH  = 2;
    localparam int STEP = 64;
    localparam int CHW  = 1;
    localparam int BW   = CHW + GW + 1 + DW;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 gain_load;
    logic [CHW-1:0]       gain_ch;
    logic signed [GW-1:0] gain_target;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic [CHW-1:0]       in_ch;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_data;
    logic [CHW-1:0]       out_ch;
    logic signed [GW-1:0] out_gain;
    logic                 out_clip;
    logic                 clip_clr;
    logic [15:0]          clip_count;

    amp_limiter_ramp #(
        .DATA_W(DW), .GAIN_W(GW), .FRAC_W(FW), .CHANNELS(NCH), .RAMP_STEP(STEP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .gain_load(gain_load), .gain_ch(gain_ch), .gain_target(gain_target),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ch(in_ch),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_gain(out_gain), .out_clip(out_clip),
        .clip_clr(clip_clr), .clip_count(clip_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference state: gains as plain integers, counter as an integer.
    int mcur [NCH] = '{256, 256};
    int mtgt [NCH] = '{256, 256};
    int mcnt = 0;
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] beat_q[$];
    bit bp_mode = 1'b0;

    task automatic check(input string tag, input longint got, input longint exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic logic [BW-1:0] model_beat(input int ch, input int data);
        int g;
        longint r;
        logic [DW-1:0] d;
        logic c;
        g = (ch < NCH) ? mcur[ch] : 0;
        r = floor_div(longint'(data) * g + 128, 256);
        if (r > 32767) begin
            d = 16'h7FFF; c = 1'b1;
        end else if (r < -32768) begin
            d = 16'h8000; c = 1'b1;
        end else begin
            d = 16'(r); c = 1'b0;
        end
        return {1'(ch), 16'(g), c, d};
    endfunction

    function automatic int ramp(input int c, input int t);
        if (t > c) return c + ((t - c < STEP) ? t - c : STEP);
        return c - ((c - t < STEP) ? c - t : STEP);
    endfunction

    function automatic int f_ch(input logic [BW-1:0] b);
        return int'(b[BW-1]);
    endfunction
    function automatic int f_gain(input logic [BW-1:0] b);
        logic signed [GW-1:0] v;
        v = b[BW-2:DW+1];
        return int'(v);
    endfunction
    function automatic int f_clip(input logic [BW-1:0] b);
        return int'(b[DW]);
    endfunction
    function automatic int f_data(input logic [BW-1:0] b);
        logic signed [DW-1:0] v;
        v = b[DW-1:0];
        return int'(v);
    endfunction

    // Scoreboard and model, evaluated mid-cycle when all inputs are settled.
    logic [BW-1:0] got;
    logic [BW-1:0] expv;
    logic [BW:0]   snap;
    bit            stall_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                mcur[c] = 256;
                mtgt[c] = 256;
            end
            mcnt = 0;
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                tests++;
                assert ({out_valid, out_ch, out_gain, out_clip, out_data} === snap) else begin
                    fails++;
                    $error("FAIL stall_hold: observed %h expected %h",
                           {out_valid, out_ch, out_gain, out_clip, out_data}, snap);
                end
            end
            stall_prev = out_valid && !out_ready;
            snap = {out_valid, out_ch, out_gain, out_clip, out_data};

            if (clip_clr) mcnt = 0;
            if (out_valid && out_ready) begin
                got = {out_ch, out_gain, out_clip, out_data};
                tests++;
                assert (exp_q.size() != 0) else begin
                    fails++;
                    $error("FAIL beat_unexpected: observed %h expected none", got);
                end
                if (exp_q.size() != 0) begin
                    expv = exp_q.pop_front();
                    tests++;
                    assert (got === expv) else begin
                        fails++;
                        $error("FAIL beat: observed %h expected %h", got, expv);
                    end
                    if (!clip_clr && expv[DW] && mcnt < 65535) mcnt++;
                end
                beat_q.push_back(got);
            end

            if (in_valid && in_ready) begin
                exp_q.push_back(model_beat(int'(in_ch), int'(in_data)));
                if (int'(in_ch) < NCH) mcur[in_ch] = ramp(mcur[in_ch], mtgt[in_ch]);
            end
            if (gain_load && int'(gain_ch) < NCH) mtgt[gain_ch] = int'(gain_target);
        end
    end

    always @(posedge clk) begin
        if (bp_mode) begin
            #1;
            if (bp_mode) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input int data, input bit ld = 1'b0, input int tgt = 0);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_ch    = 1'(ch);
        in_data  = 16'(data);
        if (ld) begin
            gain_load   = 1'b1;
            gain_ch     = 1'(ch);
            gain_target = 16'(tgt);
        end
        @(negedge clk);
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        gain_load = 1'b0;
    endtask

    task automatic load_gain(input int ch, input int tgt);
        gain_load   = 1'b1;
        gain_ch     = 1'(ch);
        gain_target = 16'(tgt);
        tick();
        gain_load = 1'b0;
    endtask

    task automatic pulse_clr();
        clip_clr = 1'b1;
        tick();
        clip_clr = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
            tick();
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int g0_exp [6];
        int k;
        rst_n = 1'b0; gain_load = 1'b0; gain_ch = '0; gain_target = '0;
        in_valid = 1'b0; in_data = '0; in_ch = '0; out_ready = 1'b1; clip_clr = 1'b0;
        g0_exp = '{256, 320, 384, 448, 512, 512};

        // Reset values
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_gain", out_gain, 0);
        check("rst_out_clip", out_clip, 0);
        check("rst_clip_count", clip_count, 0);
        rst_n = 1'b1;
        tick();

        // Unity gain and two-cycle latency
        in_valid = 1'b1; in_ch = 1'b0; in_data = 16'sd1000;
        tick();
        in_valid = 1'b0;
        check("lat_one_cycle", out_valid, 0);
        tick();
        check("lat_two_cycles", out_valid, 1);
        check("unity_pos_data", $signed(out_data), 1000);
        check("unity_gain", out_gain, 256);
        check("unity_clip", out_clip, 0);
        beat_q.delete();
        send(0, -1000);
        drain();
        check("unity_neg_data", f_data(beat_q[beat_q.size()-1]), -1000);

        // Ramp to 512 on ch0 with ch1 interleaved
        load_gain(0, 512);
        beat_q.delete();
        for (int i = 0; i < 6; i++) begin
            send(0, 100);
            send(1, 100);
        end
        drain();
        k = 0;
        foreach (beat_q[i]) begin
            if (f_ch(beat_q[i]) == 0) begin
                if (k < 6) check("ramp_ch0_gain", f_gain(beat_q[i]), g0_exp[k]);
                k++;
            end else begin
                check("ramp_ch1_gain", f_gain(beat_q[i]), 256);
            end
        end
        check("ramp_ch0_count", k, 6);

        // Load coinciding with a sample of the same channel
        beat_q.delete();
        send(0, 100, 1'b1, 256);
        send(0, 100);
        send(0, 100);
        drain();
        check("oldtgt_gain0", f_gain(beat_q[0]), 512);
        check("oldtgt_gain1", f_gain(beat_q[1]), 512);
        check("oldtgt_gain2", f_gain(beat_q[2]), 448);

        // Rounding at gain 0.5
        load_gain(0, 128);
        for (int i = 0; i < 200 && mcur[0] != 128; i++) send(0, 0);
        drain();
        beat_q.delete();
        send(0, 3);
        send(0, -3);
        send(0, 2);
        drain();
        check("round_pos3", f_data(beat_q[0]), 2);
        check("round_neg3", f_data(beat_q[1]), -1);
        check("round_pos2", f_data(beat_q[2]), 1);

        // Saturation at gain 2.0 on ch1
        load_gain(1, 512);
        for (int i = 0; i < 200 && mcur[1] != 512; i++) send(1, 0);
        drain();
        pulse_clr();
        beat_q.delete();
        send(1, 20000);
        send(1, -20000);
        send(1, 16383);
        drain();
        check("sat_gain", f_gain(beat_q[0]), 512);
        check("sat_hi_data", f_data(beat_q[0]), 32767);
        check("sat_hi_clip", f_clip(beat_q[0]), 1);
        check("sat_lo_data", f_data(beat_q[1]), -32768);
        check("sat_lo_clip", f_clip(beat_q[1]), 1);
        check("sat_edge_data", f_data(beat_q[2]), 32766);
        check("sat_edge_clip", f_clip(beat_q[2]), 0);
        check("sat_clip_count", clip_count, 2);

        // Random traffic with occasional gain loads
        for (int i = 0; i < 30; i++) begin
            send(int'($urandom_range(0, 1)), int'($urandom_range(0, 65535)) - 32768,
                 ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2047)) - 1024);
        end
        drain();
        check("rand_clip_count", clip_count, mcnt);

        // Backpressure
        bp_mode = 1'b1;
        beat_q.delete();
        for (int i = 0; i < 10; i++) begin
            send(int'($urandom_range(0, 1)), int'($urandom_range(0, 65535)) - 32768,
                 ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2047)) - 1024);
        end
        drain();
        bp_mode = 1'b0;
        tick();
        out_ready = 1'b1;
        check("bp_beat_count", beat_q.size(), 10);
        check("bp_clip_count", clip_count, mcnt);

        // Counter saturation
        load_gain(1, 512);
        for (int i = 0; i < 200 && mcur[1] != 512; i++) send(1, 0);
        drain();
        pulse_clr();
        for (int i = 0; i < 65536 + 4; i++) send(1, 20000);
        drain();
        beat_q.delete();
        check("cnt_saturated", clip_count, 65535);
        check("cnt_model", clip_count, mcnt);

        // Clear on the same edge as a clipped beat
        send(1, 20000);
        tick();
        check("clr_beat_present", out_valid && out_clip, 1);
        clip_clr = 1'b1;
        tick();
        clip_clr = 1'b0;
        check("clr_priority", clip_count, 0);

        // Reset in mid-stream
        send(1, 20000);
        drain();
        check("pre_reset_clips", clip_count, 1);
        load_gain(0, 512);
        for (int i = 0; i < 3; i++) send(0, 5);
        send(0, 7);
        send(1, 7);
        check("pre_reset_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_gain", out_gain, 0);
        check("mid_rst_out_ch", out_ch, 0);
        check("mid_rst_out_clip", out_clip, 0);
        check("mid_rst_clip_count", clip_count, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        beat_q.delete();
        send(0, 100);
        send(1, 100);
        drain();
        check("post_rst_beats", beat_q.size(), 2);
        check("post_rst_gain0", f_gain(beat_q[0]), 256);
        check("post_rst_gain1", f_gain(beat_q[1]), 256);
        check("post_rst_data0", f_data(beat_q[0]), 100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
